// File: rtl/day10_pkg.sv
// -----------------------------------------------------------------------------
// day10_pkg
// Shared definitions for the day-10 input reader and output writer:
//   - state_t     : reader FSM state encoding (3-bit enum)
//   - MAX_*_DEF   : default maximum light / button counts
//   - count_w()   : width needed to hold a count 0..max (min 1)
//   - index_w()   : width needed to hold an index 0..max-1 (min 1)
// -----------------------------------------------------------------------------
package day10_pkg;

  localparam int MAX_NUM_LIGHTS_DEF  = 16;
  localparam int MAX_NUM_BUTTONS_DEF = 16;

  typedef enum logic [2:0] {
    INIT,
    READ_NUM_LIGHTS,
    READ_TARGET,
    READ_NUM_BUTTONS,
    READ_BUTTONS,
    READER_READY
  } state_t;

  function automatic int count_w(input int max_n);
    return (max_n <= 1) ? 1 : $clog2(max_n + 1);
  endfunction

  function automatic int index_w(input int max_n);
    return (max_n <= 1) ? 1 : $clog2(max_n);
  endfunction

endpackage

// File: rtl/day10_input_reader_if.sv
// -----------------------------------------------------------------------------
// Interfaces used by day10_input_reader.
//
// axi_stream_if #(DATA_WIDTH)
//   tdata, tvalid, tlast : master -> slave
//   tready               : slave  -> master
//   modports: master, slave
//
// day10_input_if #(MAX_NUM_LIGHTS, MAX_NUM_BUTTONS)
//   num_lights    : light count (count_w(MAX_NUM_LIGHTS) bits)
//   target_lights : target pattern, bit i = light i
//   num_buttons   : button count (count_w(MAX_NUM_BUTTONS) bits)
//   button_masks  : [button][light] toggle masks
//   modports: producer (drives fields), consumer (reads fields)
// -----------------------------------------------------------------------------
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

interface day10_input_if #(
  parameter int MAX_NUM_LIGHTS  = 16,
  parameter int MAX_NUM_BUTTONS = 16
);
  import day10_pkg::*;

  localparam int NL_W = count_w(MAX_NUM_LIGHTS);
  localparam int NB_W = count_w(MAX_NUM_BUTTONS);

  logic [NL_W-1:0]                                  num_lights;
  logic [MAX_NUM_LIGHTS-1:0]                        target_lights;
  logic [NB_W-1:0]                                  num_buttons;
  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]   button_masks;

  modport producer (output num_lights, output target_lights,
                    output num_buttons, output button_masks);
  modport consumer (input num_lights, input target_lights,
                    input num_buttons, input button_masks);
endinterface

// File: rtl/axi_read_vector.sv
// -----------------------------------------------------------------------------
// axi_read_vector
// Collects i_vec_length single-bit beats (tdata[0]) into a vector, index
// ascending from 0, one bit per accepted handshake.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_start         : begin a read of i_vec_length bits (length must be > 0)
//   i_more          : sampled with o_done; 1 = another vector of the same
//                     length follows immediately (no idle cycle)
//   i_vec_length    : number of bits to read
//   i_tvalid        : stream valid
//   i_tdata0        : stream tdata[0]
//   o_tready        : stream ready (registered, independent of i_tvalid)
//   o_vector_next   : vector including the bit accepted this cycle
//   o_done          : high on the handshake of the final bit
// -----------------------------------------------------------------------------
module axi_read_vector #(
  parameter int MAX_VEC_LENGTH = 16,
  parameter int LEN_W          = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_more,
  input  logic [LEN_W-1:0]          i_vec_length,
  input  logic                      i_tvalid,
  input  logic                      i_tdata0,
  output logic                      o_tready,
  output logic [MAX_VEC_LENGTH-1:0] o_vector_next,
  output logic                      o_done
);

  logic                      r_active;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_idx;
  logic [MAX_VEC_LENGTH-1:0] r_vec;
  logic                      w_hs;

  assign o_tready = r_active;
  assign w_hs     = r_active & i_tvalid;
  assign o_done   = w_hs && (r_idx == (r_len - 1'b1));

  always_comb begin
    o_vector_next = r_vec;
    for (int unsigned i = 0; i < MAX_VEC_LENGTH; i++) begin
      if (w_hs && (r_idx == LEN_W'(i))) o_vector_next[i] = i_tdata0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_len    <= '0;
      r_idx    <= '0;
      r_vec    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_len    <= i_vec_length;
      r_idx    <= '0;
      r_vec    <= '0;
    end else if (o_done) begin
      // The owner captures o_vector_next now; restart clean for the next one.
      r_active <= i_more;
      r_idx    <= '0;
      r_vec    <= '0;
    end else if (w_hs) begin
      r_idx    <= r_idx + 1'b1;
      r_vec    <= o_vector_next;
    end
  end

endmodule

// File: rtl/day10_input_reader.sv
// -----------------------------------------------------------------------------
// day10_input_reader
// AXI-stream slave that parses one day-10 machine record per start pulse:
//   beat 0           : num_lights (saturated to MAX_NUM_LIGHTS)
//   num_lights beats : target_lights[i] = tdata[0]
//   next beat        : num_buttons (saturated to MAX_NUM_BUTTONS)
//   per button b     : num_lights beats, button_masks[b][i] = tdata[0]
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   day10_input   : parsed record fields (day10_input_if.producer)
//   start         : one-cycle request to read a record (ignored unless idle)
//   reader_ready  : one-cycle pulse, fields valid
//   last_record   : final beat of the record carried tlast; held until start
//   data_in       : AXI_DATA_WIDTH-wide input stream (axi_stream_if.slave)
//   frame_error   : only with DAY10_INPUT_READER_FRAME_CHECK_EN; sticky flag
//                   for tlast on a non-final beat or a saturated count
// -----------------------------------------------------------------------------
module day10_input_reader
  import day10_pkg::*;
#(
  parameter int MAX_NUM_LIGHTS    = MAX_NUM_LIGHTS_DEF,
  parameter int MAX_NUM_BUTTONS   = MAX_NUM_BUTTONS_DEF,
  parameter int MAX_NUM_LIGHTS_W  = count_w(MAX_NUM_LIGHTS),
  parameter int MAX_NUM_BUTTONS_W = count_w(MAX_NUM_BUTTONS),
  parameter int AXI_DATA_WIDTH    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  day10_input_if.producer   day10_input,
  input  logic              start,
  output logic              reader_ready,
  output logic              last_record,
`ifdef DAY10_INPUT_READER_FRAME_CHECK_EN
  output logic              frame_error,
`endif
  axi_stream_if.slave       data_in
);

  localparam logic [MAX_NUM_LIGHTS_W-1:0]  MAX_NL = MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS);
  localparam logic [MAX_NUM_BUTTONS_W-1:0] MAX_NB = MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS);

  state_t r_state;
  state_t w_state_next;

  logic [MAX_NUM_LIGHTS_W-1:0]                     r_num_lights;
  logic [MAX_NUM_LIGHTS-1:0]                       r_target;
  logic [MAX_NUM_BUTTONS_W-1:0]                    r_num_buttons;
  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]  r_masks;
  logic [MAX_NUM_BUTTONS_W-1:0]                    r_btn_idx;
  logic                                            r_last_record;

  logic [MAX_NUM_LIGHTS_W-1:0]  w_nl_raw, w_nl_sat;
  logic [MAX_NUM_BUTTONS_W-1:0] w_nb_raw, w_nb_sat;
  logic                         w_tready, w_hs;
  logic                         w_sub_start, w_sub_more, w_sub_tready, w_sub_done;
  logic [MAX_NUM_LIGHTS_W-1:0]  w_sub_len;
  logic [MAX_NUM_LIGHTS-1:0]    w_sub_vec;
  logic                         w_last_btn, w_final_beat, w_nl_zero;
  logic                         w_unused_tdata;

  assign w_unused_tdata = ^data_in.tdata;

  assign w_nl_raw = data_in.tdata[MAX_NUM_LIGHTS_W-1:0];
  assign w_nb_raw = data_in.tdata[MAX_NUM_BUTTONS_W-1:0];
  assign w_nl_sat = (w_nl_raw > MAX_NL) ? MAX_NL : w_nl_raw;
  assign w_nb_sat = (w_nb_raw > MAX_NB) ? MAX_NB : w_nb_raw;

  // Count beats are accepted by the FSM itself; vector beats by the
  // sub-module. Both sources are registered, so tready never sees tvalid.
  assign w_tready = (r_state == READ_NUM_LIGHTS) || (r_state == READ_NUM_BUTTONS)
                    || w_sub_tready;
  assign w_hs     = data_in.tvalid & w_tready;
  assign data_in.tready = w_tready;

  assign w_last_btn = (r_btn_idx == (r_num_buttons - 1'b1));
  assign w_nl_zero  = (r_num_lights == '0);

  axi_read_vector #(
    .MAX_VEC_LENGTH (MAX_NUM_LIGHTS),
    .LEN_W          (MAX_NUM_LIGHTS_W)
  ) u_read_vec (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (w_sub_start),
    .i_more        (w_sub_more),
    .i_vec_length  (w_sub_len),
    .i_tvalid      (data_in.tvalid),
    .i_tdata0      (data_in.tdata[0]),
    .o_tready      (w_sub_tready),
    .o_vector_next (w_sub_vec),
    .o_done        (w_sub_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_sub_start  = 1'b0;
    w_sub_more   = 1'b0;
    w_sub_len    = r_num_lights;
    w_final_beat = 1'b0;
    reader_ready = 1'b0;
    unique case (r_state)
      INIT: begin
        if (start) w_state_next = READ_NUM_LIGHTS;
      end
      READ_NUM_LIGHTS: begin
        // Length not yet registered: hand the incoming count straight over.
        w_sub_len = w_nl_sat;
        if (w_hs) begin
          if (w_nl_sat == '0) begin
            w_state_next = READ_NUM_BUTTONS;
          end else begin
            w_sub_start  = 1'b1;
            w_state_next = READ_TARGET;
          end
        end
      end
      READ_TARGET: begin
        if (w_sub_done) w_state_next = READ_NUM_BUTTONS;
      end
      READ_NUM_BUTTONS: begin
        if (w_hs) begin
          if ((w_nb_sat == '0) || w_nl_zero) begin
            w_final_beat = 1'b1;
            w_state_next = READER_READY;
          end else begin
            w_sub_start  = 1'b1;
            w_state_next = READ_BUTTONS;
          end
        end
      end
      READ_BUTTONS: begin
        w_sub_more = !w_last_btn;
        if (w_sub_done && w_last_btn) begin
          w_final_beat = 1'b1;
          w_state_next = READER_READY;
        end
      end
      READER_READY: begin
        reader_ready = 1'b1;
        w_state_next = INIT;
      end
      default: w_state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_lights  <= '0;
      r_target      <= '0;
      r_num_buttons <= '0;
      r_masks       <= '0;
      r_btn_idx     <= '0;
      r_last_record <= 1'b0;
    end else begin
      unique case (r_state)
        INIT: begin
          if (start) begin
            r_num_lights  <= '0;
            r_target      <= '0;
            r_num_buttons <= '0;
            r_masks       <= '0;
            r_btn_idx     <= '0;
            r_last_record <= 1'b0;
          end
        end
        READ_NUM_LIGHTS: begin
          if (w_hs) r_num_lights <= w_nl_sat;
        end
        READ_TARGET: begin
          if (w_sub_done) r_target <= w_sub_vec;
        end
        READ_NUM_BUTTONS: begin
          if (w_hs) begin
            r_num_buttons <= w_nb_sat;
            r_btn_idx     <= '0;
          end
        end
        READ_BUTTONS: begin
          if (w_sub_done) begin
            for (int unsigned b = 0; b < MAX_NUM_BUTTONS; b++) begin
              if (r_btn_idx == MAX_NUM_BUTTONS_W'(b)) r_masks[b] <= w_sub_vec;
            end
            if (!w_last_btn) r_btn_idx <= r_btn_idx + 1'b1;
          end
        end
        default: ;
      endcase
      if (w_final_beat) r_last_record <= data_in.tlast;
    end
  end

`ifdef DAY10_INPUT_READER_FRAME_CHECK_EN
  logic r_frame_error;
  logic w_sat_hit;

  assign w_sat_hit = ((r_state == READ_NUM_LIGHTS)  && (w_nl_raw > MAX_NL)) ||
                     ((r_state == READ_NUM_BUTTONS) && (w_nb_raw > MAX_NB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_error <= 1'b0;
    end else if ((r_state == INIT) && start) begin
      r_frame_error <= 1'b0;
    end else if (w_hs && ((data_in.tlast && !w_final_beat) || w_sat_hit)) begin
      r_frame_error <= 1'b1;
    end
  end

  assign frame_error = r_frame_error;
`endif

  assign day10_input.num_lights    = r_num_lights;
  assign day10_input.target_lights = r_target;
  assign day10_input.num_buttons   = r_num_buttons;
  assign day10_input.button_masks  = r_masks;
  assign last_record               = r_last_record;

endmodule

// File: tb/tb_day10_input_reader.sv
// -----------------------------------------------------------------------------
// tb_day10_input_reader
// Directed table of records with hand-computed expectations, a reset-in-the-
// middle sequence, then randomized records checked against a record-level
// reference model (saturation and zero-length rules applied arithmetically).
// -----------------------------------------------------------------------------
module tb_day10_input_reader;

  localparam int BUDGET = 3000;

  typedef struct {
    int                 nl_raw;
    int                 nb_raw;
    logic [15:0]        tgt;
    logic [15:0][15:0]  masks;
    bit                 fin_tlast;
    int                 early_tlast;
    int                 gap;
    bit                 stray;
    int                 exp_beats;
    int                 exp_nl;
    int                 exp_nb;
    logic [15:0]        exp_tgt;
    logic [15:0][15:0]  exp_masks;
    bit                 exp_last;
    bit                 exp_ferr;
  } rec_t;

  logic clk;
  logic rst_n;
  logic start;
  logic reader_ready;
  logic last_record;
`ifdef DAY10_INPUT_READER_FRAME_CHECK_EN
  logic frame_error;
`endif

  axi_stream_if #(.DATA_WIDTH(8)) axis ();
  day10_input_if #(.MAX_NUM_LIGHTS(16), .MAX_NUM_BUTTONS(16)) d10 ();

  day10_input_reader #(
    .MAX_NUM_LIGHTS  (16),
    .MAX_NUM_BUTTONS (16),
    .AXI_DATA_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .day10_input  (d10.producer),
    .start        (start),
    .reader_ready (reader_ready),
    .last_record  (last_record),
`ifdef DAY10_INPUT_READER_FRAME_CHECK_EN
    .frame_error  (frame_error),
`endif
    .data_in      (axis.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  rec_t tab[7];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sat16(input int raw);
    int v;
    v = raw % 32;
    return (v > 16) ? 16 : v;
  endfunction

  function automatic rec_t mk(input int nl, input int nb, input logic [15:0] tgt,
                              input logic [15:0] m0, input logic [15:0] m1,
                              input bit fin, input int early, input int gap, input bit stray,
                              input int eb, input int enl, input int enb,
                              input logic [15:0] et, input logic [15:0] em0,
                              input logic [15:0] em1, input bit el, input bit ef);
    rec_t r;
    r.nl_raw = nl; r.nb_raw = nb; r.tgt = tgt;
    r.masks = '0; r.masks[0] = m0; r.masks[1] = m1;
    r.fin_tlast = fin; r.early_tlast = early; r.gap = gap; r.stray = stray;
    r.exp_beats = eb; r.exp_nl = enl; r.exp_nb = enb; r.exp_tgt = et;
    r.exp_masks = '0; r.exp_masks[0] = em0; r.exp_masks[1] = em1;
    r.exp_last = el; r.exp_ferr = ef;
    return r;
  endfunction

  // Record-level reference: what a reader must present after this record.
  function automatic rec_t model(input rec_t r);
    rec_t o;
    int   L, B, nl5, nb5;
    o   = r;
    nl5 = r.nl_raw % 32;
    nb5 = r.nb_raw % 32;
    L   = sat16(r.nl_raw);
    B   = sat16(r.nb_raw);
    o.exp_nl    = L;
    o.exp_nb    = B;
    o.exp_beats = 2 + L + B * L;
    o.exp_tgt   = '0;
    o.exp_masks = '0;
    for (int i = 0; i < L; i++) o.exp_tgt[i] = r.tgt[i];
    for (int b = 0; b < B; b++)
      for (int i = 0; i < L; i++) o.exp_masks[b][i] = r.masks[b][i];
    o.exp_last = r.fin_tlast;
    o.exp_ferr = (r.early_tlast >= 0) || (nl5 > 16) || (nb5 > 16);
    return o;
  endfunction

  // Called at #1 after a posedge with the DUT idle; returns at #1 after a
  // posedge, one cycle after the ready pulse (or after stop_at handshakes).
  task automatic run_rec(input rec_t r, input int stop_at, output int hs, output int lat,
                         output bit got_ready, output bit ready_low_after);
    logic [7:0] q[$];
    bit         tl[$];
    int         L, B, n, k, extra, cyc, since;
    bit         hs_now, stray_done;
    L = sat16(r.nl_raw);
    B = sat16(r.nb_raw);
    q.push_back({3'($urandom), 5'(r.nl_raw)});
    for (int i = 0; i < L; i++) q.push_back({7'($urandom), r.tgt[i]});
    q.push_back({3'($urandom), 5'(r.nb_raw)});
    if (L > 0)
      for (int b = 0; b < B; b++)
        for (int i = 0; i < L; i++) q.push_back({7'($urandom), r.masks[b][i]});
    n = q.size();
    for (int i = 0; i < n; i++) tl.push_back((i == n - 1) ? r.fin_tlast : (i == r.early_tlast));
    k = 0; extra = 0; cyc = 0; since = 0; lat = -1;
    got_ready = 1'b0; ready_low_after = 1'b0; stray_done = 1'b0; hs = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!got_ready && cyc < BUDGET) begin
      if (k < n) begin
        case (r.gap)
          1:       axis.tvalid = (cyc % 2 == 0);
          2:       axis.tvalid = ($urandom_range(0, 9) >= 3);
          default: axis.tvalid = 1'b1;
        endcase
        axis.tdata = q[k];
        axis.tlast = tl[k];
      end else begin
        // Extra beats offered after the record: none may be taken.
        axis.tvalid = 1'b1;
        axis.tdata  = 8'($urandom);
        axis.tlast  = 1'b0;
      end
      if (r.stray && !stray_done && k == 5) begin
        start = 1'b1;
        stray_done = 1'b1;
      end
      @(negedge clk);
      if (k == n) since++;
      if (reader_ready) begin
        got_ready = 1'b1;
        lat = since;
      end
      hs_now = axis.tvalid && axis.tready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs_now) begin
        if (k < n) k++;
        else       extra++;
      end
      cyc++;
      if (stop_at >= 0 && k == stop_at) begin
        axis.tvalid = 1'b0;
        hs = k;
        return;
      end
    end
    axis.tvalid = 1'b0;
    ready_low_after = !reader_ready;
    hs = k + extra;
  endtask

  task automatic check_rec(input string tag, input rec_t r, input int hs, input int lat,
                           input bit got, input bit low);
    chk({tag, ".ready_seen"}, 256'(got), 256'(1));
    chk({tag, ".beats"}, 256'(hs), 256'(r.exp_beats));
    chk({tag, ".latency"}, 256'(lat), 256'(1));
    chk({tag, ".pulse_1cyc"}, 256'(low), 256'(1));
    chk({tag, ".num_lights"}, 256'(d10.num_lights), 256'(r.exp_nl));
    chk({tag, ".num_buttons"}, 256'(d10.num_buttons), 256'(r.exp_nb));
    chk({tag, ".target"}, 256'(d10.target_lights), 256'(r.exp_tgt));
    chk({tag, ".masks"}, d10.button_masks, r.exp_masks);
    chk({tag, ".last_record"}, 256'(last_record), 256'(r.exp_last));
    chk({tag, ".idle_tready"}, 256'(axis.tready), 256'(0));
`ifdef DAY10_INPUT_READER_FRAME_CHECK_EN
    chk({tag, ".frame_error"}, 256'(frame_error), 256'(r.exp_ferr));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hs, lat;
    bit   got, low;
    rec_t r;

    rst_n = 1'b0; start = 1'b0;
    axis.tvalid = 1'b0; axis.tdata = '0; axis.tlast = 1'b0;

    //          nl  nb  tgt      m0       m1       fin early gap stray  beats nl nb  et       em0      em1      last ferr
    tab[0] = mk(4,  2,  16'h000D,16'h0003,16'h000A,1,  -1,   0,  0,     14,   4, 2,  16'h000D,16'h0003,16'h000A,1,   0);
    tab[1] = mk(4,  2,  16'h000D,16'h0003,16'h000A,1,  -1,   1,  1,     14,   4, 2,  16'h000D,16'h0003,16'h000A,1,   0);
    tab[2] = mk(0,  3,  16'h0000,16'h0000,16'h0000,0,  -1,   0,  0,     2,    0, 3,  16'h0000,16'h0000,16'h0000,0,   0);
    tab[3] = mk(3,  0,  16'h0006,16'h0000,16'h0000,1,  -1,   2,  0,     5,    3, 0,  16'h0006,16'h0000,16'h0000,1,   0);
    tab[4] = mk(20, 1,  16'hA5C3,16'h1234,16'h0000,0,  -1,   0,  0,     34,  16, 1,  16'hA5C3,16'h1234,16'h0000,0,   1);
    tab[5] = mk(4,  2,  16'h000D,16'h0003,16'h000A,0,   2,   0,  0,     14,   4, 2,  16'h000D,16'h0003,16'h000A,0,   1);
    tab[6] = mk(2,  25, 16'h0000,16'h0002,16'h0001,1,  -1,   0,  0,     36,   2, 16, 16'h0000,16'h0002,16'h0001,1,   1);

    #3;
    chk("reset.tready", 256'(axis.tready), 256'(0));
    chk("reset.reader_ready", 256'(reader_ready), 256'(0));
    chk("reset.last_record", 256'(last_record), 256'(0));
    chk("reset.fields", {d10.button_masks}, '0);
    chk("reset.counts", 256'({d10.num_lights, d10.num_buttons, d10.target_lights}), '0);
`ifdef DAY10_INPUT_READER_FRAME_CHECK_EN
    chk("reset.frame_error", 256'(frame_error), 256'(0));
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, records issued back to back.
    for (int t = 0; t < 7; t++) begin
      run_rec(tab[t], -1, hs, lat, got, low);
      check_rec($sformatf("tab%0d", t), tab[t], hs, lat, got, low);
    end

    // Reset while inside the button masks: 1 + 4 + 1 + 2 handshakes.
    run_rec(tab[0], 8, hs, lat, got, low);
    chk("rst_mid.hs_before", 256'(hs), 256'(8));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.tready", 256'(axis.tready), 256'(0));
    chk("rst_mid.num_lights", 256'(d10.num_lights), 256'(0));
    chk("rst_mid.target", 256'(d10.target_lights), 256'(0));
    chk("rst_mid.num_buttons", 256'(d10.num_buttons), 256'(0));
    chk("rst_mid.masks", d10.button_masks, '0);
    chk("rst_mid.ready", 256'(reader_ready), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_rec(tab[0], -1, hs, lat, got, low);
    check_rec("after_rst", tab[0], hs, lat, got, low);

    // Randomized records against the reference model.
    for (int t = 0; t < 30; t++) begin
      r.nl_raw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 8));
      r.nb_raw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 6));
      r.tgt    = 16'($urandom);
      for (int b = 0; b < 16; b++) r.masks[b] = 16'($urandom);
      r.fin_tlast   = 1'($urandom_range(0, 1));
      r.early_tlast = ($urandom_range(0, 3) == 0) ? 0 : -1;
      r.gap         = int'($urandom_range(0, 2));
      r.stray       = 1'($urandom_range(0, 1));
      r = model(r);
      run_rec(r, -1, hs, lat, got, low);
      check_rec($sformatf("rnd%0d", t), r, hs, lat, got, low);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/day10_input_reader.md
Name: day10_input_reader

Overview:
- AXI-stream slave that parses one day-10 machine record per `start` pulse into the `day10_input_if` fields: light count, target light pattern, button count and per-button toggle masks.
- Sits between the input DMA stream and the day-10 solver.
- Mirror of the day-10 output writer: `start`, ready pulse, and a last flag marking the final record of the stream.

Parameters:
- MAX_NUM_LIGHTS, 16, maximum lights per machine (vector length of target and masks).
- MAX_NUM_BUTTONS, 16, maximum buttons per machine.
- MAX_NUM_LIGHTS_W, $clog2(MAX_NUM_LIGHTS+1) (1 if MAX≤1), width of the light count.
- MAX_NUM_BUTTONS_W, $clog2(MAX_NUM_BUTTONS+1) (1 if MAX≤1), width of the button count.
- AXI_DATA_WIDTH, 8, tdata width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- day10_input  interface  day10_input_if.producer  outputs num_lights, target_lights[MAX_NUM_LIGHTS], num_buttons, button_masks[MAX_NUM_BUTTONS][MAX_NUM_LIGHTS].
- start  input  1  single-cycle request to read one record.
- reader_ready  output  1  one-cycle pulse: record fully captured, fields valid.
- last_record  output  1  record just read ended the stream (tlast on its final beat); valid with reader_ready, held until the next start.
- data_in  interface  axi_stream_if.slave  AXI_DATA_WIDTH-wide input stream.

Behaviour:
- Reset (asynchronous, rst_n low): state INIT; tready=0, reader_ready=0, last_record=0, all day10_input fields 0. Reset mid-record abandons the record; no partial state survives.
- Beat format, one beat per accepted handshake (tvalid && tready):
  - beat 0: num_lights = tdata[MAX_NUM_LIGHTS_W-1:0], saturated to MAX_NUM_LIGHTS.
  - next num_lights beats: target_lights[i] = tdata[0], i ascending from 0.
  - next beat: num_buttons, saturated to MAX_NUM_BUTTONS.
  - then for each button b ascending, num_lights beats: button_masks[b][i] = tdata[0].
- Vector bits at index ≥ length are cleared to 0 on start.
- States: INIT → READ_NUM_LIGHTS → READ_TARGET → READ_NUM_BUTTONS → READ_BUTTONS → READER_READY → INIT.
  - INIT: tready=0; on start clear the fields and last_record, go to READ_NUM_LIGHTS. A start outside INIT is ignored.
  - READ_NUM_LIGHTS / READ_NUM_BUTTONS: tready=1; advance on handshake.
  - READ_TARGET / READ_BUTTONS: tready=1; index counters advance only on handshake. Light index wraps to 0 after num_lights-1 and increments the button index; leave after the last bit of the last button.
  - Zero lengths: num_lights=0 goes straight from READ_NUM_LIGHTS to READ_NUM_BUTTONS. num_buttons=0 or num_lights=0 goes from READ_NUM_BUTTONS straight to READER_READY, with no mask beats.
  - READER_READY: reader_ready=1 for exactly one cycle, tready=0, then INIT.
- tvalid low stalls with no state change; no combinational path from tvalid to tready.
- last_record is set when the record's final beat handshakes with tlast=1.
- Throughput: one beat per cycle. Latency from final handshake to reader_ready is 1 cycle.

Optional Feature:
- Macro: DAY10_INPUT_READER_FRAME_CHECK_EN.
- Defined:
  - Extra output port `frame_error` (1 bit), reset 0, cleared on start.
  - Set sticky when tlast=1 on any non-final beat of a record. The record still completes normally.
  - Also asserted when a saturated count exceeded its maximum.
- Undefined:
  - Port absent.
  - tlast is sampled only on the final beat; no saturation flagging.

Decomposition:
- Package day10_pkg: state_t enum (3-bit), MAX defaults, and the light/button index width helpers shared with the output writer.
- Sub-module axi_read_vector (counterpart of axi_write_vector):
  - Inputs: start, vec_length; drives tready.
  - Shifts tdata[0] bits into a MAX_VEC_LENGTH vector and pulses done.
  - Instantiated once per vector read (target, and reused per button).

Test Plan:
- Basic record: num_lights=4, target 1,0,1,1; num_buttons=2; masks 1,1,0,0 and 0,1,0,1; tlast on final beat → target_lights=4'b1101, button_masks[0]=4'b0011, button_masks[1]=4'b1010, reader_ready pulses 1 cycle after last handshake, last_record=1.
- Backpressure: same record with tvalid low every other cycle → identical fields; counters frozen on idle cycles; 14 handshakes total.
- Zero lengths: num_lights=0, num_buttons=3 → only 2 beats consumed, masks all 0, reader_ready pulses. Also num_lights=3, num_buttons=0 → 5 beats consumed.
- Saturation: num_lights beat = 20 with MAX 16 → 16 target beats consumed. With FRAME_CHECK_EN, frame_error=1.
- Reset mid-record: rst_n low during READ_BUTTONS → tready=0 and all fields 0 immediately. Next start reads a fresh record correctly.
- Early tlast (FRAME_CHECK_EN): tlast on the 2nd target beat → frame_error=1, record completes, last_record=0. Back-to-back start after ready reads a second record without stall.
